wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, default 32, register/data width.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 rdy  input  1  global ready; when low, all state holds.
REQ-006 in_valid  input  1  MEM stage presents an instruction.
REQ-007 in_ready  output  1  this stage accepts the instruction this cycle.
REQ-008 in_rd_we / in_rd_addr  input  1 / ADDR_W  destination write enable / index.
REQ-009 in_result  input  XLEN  ALU result (non-load) or load byte address (load).
REQ-010 in_is_load / in_funct3  input  1 / 3  load flag / RISC-V load funct3.
REQ-011 dmem_rvalid / dmem_rdata  input  1 / XLEN  memory read response; word-aligned data.
REQ-012 stall_req  output  1  stall request to upstream pipeline.
REQ-013 rf_we / rf_waddr / rf_wdata  output  1 / ADDR_W / XLEN  register-file write port.
REQ-014 exc_load  output  1  one-cycle pulse: misaligned or illegal-funct3 load retired.
REQ-015 instret  output  64  retired-instruction counter.

Function
REQ-016 States: EMPTY (nothing held), WAIT (load awaiting dmem_rvalid), RETIRE (write presented this cycle).
REQ-017 Accept = in_valid & in_ready & rdy; in_ready = (state != WAIT).
REQ-018 Non-load accept: next cycle state RETIRE, rf_wdata = in_result; latency exactly 1 cycle.
REQ-019 Load accept: next state WAIT, stall_req = 1 combinationally from the cycle after accept until dmem_rvalid.
REQ-020 In WAIT with dmem_rvalid & rdy: aligned data captured, next state RETIRE; stall_req deasserted in that same cycle.
REQ-021 dmem_rvalid in EMPTY or RETIRE is ignored; no state change.
REQ-022 RETIRE with accept: back-to-back; next state per REQ-018/019; with no accept: next state EMPTY.
REQ-023 rf_we = 1 only in RETIRE and only if captured rd_we = 1, rd_addr != 0 and no exception.
REQ-024 rf_waddr/rf_wdata hold last captured values outside RETIRE; rf_we = 0 outside RETIRE.
REQ-025 Alignment by addr[1:0]: lb/lbu select byte addr[1:0], sign-/zero-extend; lh/lhu select halfword addr[1], sign-/zero-extend; lw full word.
REQ-026 Misaligned: lh/lhu with addr[0]=1, lw with addr[1:0]!=0; funct3 011/110/111 illegal; either -> no write, exc_load = 1 in RETIRE cycle.
REQ-027 Exception detection computed at accept; load still waits for dmem_rvalid before RETIRE.
REQ-028 instret increments by 1 in every RETIRE cycle with rdy = 1, including exception retires; wraps modulo 2^64.
REQ-029 rdy low: state, captured fields and instret hold; in_ready, rf_we and exc_load forced 0; stall_req keeps its value.

Reset
REQ-030 rst low at a clock edge: state EMPTY, rf_we 0, rf_waddr 0, rf_wdata 0, exc_load 0, stall_req 0, instret 0.
REQ-031 Reset during WAIT abandons the load; a subsequent dmem_rvalid is ignored per REQ-021.
REQ-032 Reset overrides rdy.

Structure
REQ-033 Shared defines file holds RegBus, RegAddrBus, ZeroWord, load funct3 codes (LB, LH, LW, LBU, LHU) and state encodings.
REQ-034 Combinational sub-module load_align (funct3, addr[1:0], rdata -> data, misalign, illegal); rest in wb_stage.
REQ-035 Only REQ-012 and REQ-029 outputs are combinational; all other outputs are registered.

Verification
REQ-036 Non-load rd=5, result 0x1234_5678 accepted at cycle N -> cycle N+1: rf_we=1, waddr=5, wdata=0x1234_5678, instret=1.
REQ-037 lb addr 0x...03, dmem_rdata 0x80FF_FF7F, rvalid 2 cycles after accept -> stall_req for 2 cycles, then rf_wdata=0xFFFF_FF80; lbu same -> 0x0000_0080.
REQ-038 lh addr 0x...01 -> rf_we=0, exc_load=1 for one cycle, instret incremented; funct3 011 -> same.
REQ-039 Back-to-back non-loads rd=1,2,3 on consecutive cycles -> three consecutive RETIRE cycles, in_ready constantly 1; write to rd=0 -> rf_we=0.
REQ-040 rdy low 3 cycles during WAIT with rvalid pulsed while rdy low -> nothing retired, still WAIT; rvalid after rdy returns -> retire.
REQ-041 rst low during WAIT, then rvalid -> state EMPTY, no write, instret=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared widths, load funct3 codes and state encodings for the write-back stage
package wb_stage_pkg;

   localparam int REG_BUS_W      = 32;
   localparam int REG_ADDR_BUS_W = 5;

   typedef logic [REG_BUS_W-1:0]      reg_bus_t;
   typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_bus_t;

   localparam reg_bus_t ZERO_WORD = '0;

   // RISC-V load funct3 codes; 011, 110 and 111 are not loads
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_WAIT   = 2'd1,
      ST_RETIRE = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - load data alignment, extension and misalign/illegal detection
module wb_stage_load_align
   import wb_stage_pkg::*;
#(
   parameter int XLEN = REG_BUS_W
) (
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_addr,
   input  logic [XLEN-1:0] i_rdata,
   output logic [XLEN-1:0] o_data,
   output logic            o_misalign,
   output logic            o_illegal
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // pick the addressed byte and halfword out of the word-aligned read data
   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   // extend according to the load type and flag bad alignment or unknown funct3
   always_comb begin
      o_data     = i_rdata;
      o_misalign = 1'b0;
      o_illegal  = 1'b0;
      case (i_funct3)
         F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
         F3_LH: begin
            o_data     = {{(XLEN-16){w_half[15]}}, w_half};
            o_misalign = i_addr[0];
         end
         F3_LHU: begin
            o_data     = {{(XLEN-16){1'b0}}, w_half};
            o_misalign = i_addr[0];
         end
         F3_LW: begin
            o_data     = i_rdata;
            o_misalign = |i_addr;
         end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: retires ALU results and aligned load data into the register file
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int XLEN   = REG_BUS_W,
   parameter int ADDR_W = REG_ADDR_BUS_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_rd_we,
   input  logic [ADDR_W-1:0] in_rd_addr,
   input  logic [XLEN-1:0]   in_result,
   input  logic              in_is_load,
   input  logic [2:0]        in_funct3,
   input  logic              dmem_rvalid,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              stall_req,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              exc_load,
   output logic [63:0]       instret
);

   wb_state_e         r_state;
   wb_state_e         w_state_nxt;
   logic              r_rd_we_ok;
   logic              r_exc;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [2:0]        r_funct3;
   logic [1:0]        r_addr_lo;
   logic [63:0]       r_instret;

   logic              w_accept;
   logic              w_capture;
   logic [2:0]        w_al_funct3;
   logic [1:0]        w_al_addr;
   logic [XLEN-1:0]   w_al_data;
   logic              w_al_misalign;
   logic              w_al_illegal;
   logic              w_exc_in;

   assign in_ready  = (r_state != ST_WAIT) && rdy;
   assign w_accept  = in_valid && in_ready;
   assign w_capture = (r_state == ST_WAIT) && dmem_rvalid;

   // accept never happens in WAIT and capture only happens in WAIT, so one aligner
   // serves both: exception check on the incoming load, data alignment on the response
   assign w_al_funct3 = (r_state == ST_WAIT) ? r_funct3  : in_funct3;
   assign w_al_addr   = (r_state == ST_WAIT) ? r_addr_lo : in_result[1:0];
   assign w_exc_in    = in_is_load && (w_al_misalign || w_al_illegal);

   wb_stage_load_align #(.XLEN(XLEN)) u_load_align (
      .i_funct3   (w_al_funct3),
      .i_addr     (w_al_addr),
      .i_rdata    (dmem_rdata),
      .o_data     (w_al_data),
      .o_misalign (w_al_misalign),
      .o_illegal  (w_al_illegal)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state plus the combinational stall and rdy-gated retire strobes
   always_comb begin
      w_state_nxt = r_state;
      stall_req   = 1'b0;
      rf_we       = 1'b0;
      exc_load    = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) w_state_nxt = in_is_load ? ST_WAIT : ST_RETIRE;
         end
         ST_WAIT: begin
            stall_req = !(dmem_rvalid && rdy);
            if (dmem_rvalid && rdy) w_state_nxt = ST_RETIRE;
         end
         ST_RETIRE: begin
            rf_we    = rdy && r_rd_we_ok;
            exc_load = rdy && r_exc;
            if (rdy) begin
               if (w_accept) w_state_nxt = in_is_load ? ST_WAIT : ST_RETIRE;
               else          w_state_nxt = ST_EMPTY;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // capture instruction fields at accept, load data at response, count retires
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rd_we_ok <= 1'b0;
         r_exc      <= 1'b0;
         r_rd_addr  <= '0;
         r_wdata    <= '0;
         r_funct3   <= 3'b000;
         r_addr_lo  <= 2'b00;
         r_instret  <= 64'd0;
      end else if (rdy) begin
         if (w_accept) begin
            r_rd_we_ok <= in_rd_we && (|in_rd_addr) && !w_exc_in;
            r_exc      <= w_exc_in;
            r_rd_addr  <= in_rd_addr;
            r_funct3   <= in_funct3;
            r_addr_lo  <= in_result[1:0];
            if (!in_is_load) r_wdata <= in_result;
         end else if (w_capture) begin
            r_wdata <= w_al_data;
         end
         // bump on the edge entering RETIRE so the count already covers the retiring instruction
         if (w_state_nxt == ST_RETIRE) r_instret <= r_instret + 64'd1;
      end
   end

   assign rf_waddr = r_rd_addr;
   assign rf_wdata = r_wdata;
   assign instret  = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed scoreboard bench for wb_stage
module tb_wb_stage;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        exc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        in_valid;
   logic        in_ready;
   logic        in_rd_we;
   logic [4:0]  in_rd_addr;
   logic [31:0] in_result;
   logic        in_is_load;
   logic [2:0]  in_funct3;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        stall_req;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        exc_load;
   logic [63:0] instret;

   int          checks   = 0;
   int          failures = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   logic [63:0] exp_instret = 64'd0;

   wb_stage dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_rd_we    (in_rd_we),
      .in_rd_addr  (in_rd_addr),
      .in_result   (in_result),
      .in_is_load  (in_is_load),
      .in_funct3   (in_funct3),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata),
      .stall_req   (stall_req),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .exc_load    (exc_load),
      .instret     (instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                        input logic [31:0] res, input logic ld, input logic [2:0] f3);
      in_valid   = v;
      in_rd_we   = we;
      in_rd_addr = rd;
      in_result  = res;
      in_is_load = ld;
      in_funct3  = f3;
   endtask

   task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] d, input logic exc);
      exp_t e;
      e.we = we; e.addr = rd; e.data = d; e.exc = exc;
      sb.push_back(e);
      exp_instret = exp_instret + 64'd1;
   endtask

   // scoreboard: every visible retire must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst && (rf_we || exc_load)) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_retire", 64'd0, 64'd1);
         end else begin
            mon_e = sb.pop_front();
            check("sb_we", 64'(rf_we), 64'(mon_e.we));
            check("sb_exc", 64'(exc_load), 64'(mon_e.exc));
            check("sb_waddr", 64'(rf_waddr), 64'(mon_e.addr));
            if (mon_e.we) check("sb_wdata", 64'(rf_wdata), 64'(mon_e.data));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; rdy = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000);
      step(); step();
      #1;
      check("rst_rf_we", 64'(rf_we), 64'd0);
      check("rst_waddr", 64'(rf_waddr), 64'd0);
      check("rst_wdata", 64'(rf_wdata), 64'd0);
      check("rst_exc", 64'(exc_load), 64'd0);
      check("rst_stall", 64'(stall_req), 64'd0);
      check("rst_instret", instret, 64'd0);
      rst = 1'b1;
      step();

      // single non-load, one-cycle latency
      drive(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'b000);
      push(1'b1, 5'd5, 32'h1234_5678, 1'b0);
      #1 check("nl_in_ready", 64'(in_ready), 64'd1);
      step();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000);
      #1 check("nl_rf_we", 64'(rf_we), 64'd1);
      check("nl_instret", instret, 64'd1);
      step();
      #1 check("nl_idle_we", 64'(rf_we), 64'd0);
      check("nl_hold_waddr", 64'(rf_waddr), 64'd5);

      // lb with two stall cycles
      drive(1'b1, 1'b1, 5'd7, 32'h0000_0103, 1'b1, 3'b000);
      push(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0);
      step();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000);
      #1 check("lb_stall1", 64'(stall_req), 64'd1);
      check("lb_in_ready", 64'(in_ready), 64'd0);
      step();
      #1 check("lb_stall2", 64'(stall_req), 64'd1);
      dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FF7F;
      #1 check("lb_stall_drop", 64'(stall_req), 64'd0);
      step();
      dmem_rvalid = 1'b0;
      // lbu issued back-to-back with the lb retire
      drive(1'b1, 1'b1, 5'd8, 32'h0000_0103, 1'b1, 3'b100);
      push(1'b1, 5'd8, 32'h0000_0080, 1'b0);
      #1 check("lb_instret", instret, exp_instret - 64'd1);
      step();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000);
      step();
      dmem_rvalid = 1'b1;
      step();
      dmem_rvalid = 1'b0;
      #1 check("lbu_instret", instret, exp_instret);
      step();

      // lh upper half, sign-extended
      drive(1'b1, 1'b1, 5'd13, 32'h0000_0102, 1'b1, 3'b001);
      push(1'b1, 5'd13, 32'hFFFF_80FF, 1'b0);
      step();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000);
      dmem_rvalid = 1'b1;
      step();
      dmem_rvalid = 1'b0;
      step();

      // misaligned lh: exception retire, no write
      drive(1'b1, 1'b1, 5'd9, 32'h0000_0101, 1'b1, 3'b001);
      push(1'b0, 5'd9, 32'h0, 1'b1);
      step();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000);
      #1 check("mis_waits", 64'(stall_req), 64'd1);
      dmem_rvalid = 1'b1;
      step();
      dmem_rvalid = 1'b0;
      #1 check("mis_instret", instret, exp_instret);
      step();
      #1 check("mis_exc_pulse", 64'(exc_load), 64'd0);

      // illegal funct3 011
      drive(1'b1, 1'b1, 5'd10, 32'h0000_0100, 1'b1, 3'b011);
      push(1'b0, 5'd10, 32'h0, 1'b1);
      step();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000);
      dmem_rvalid = 1'b1;
      step();
      dmem_rvalid = 1'b0;
      #1 check("ill_instret", instret, exp_instret);
      step();

      // back-to-back non-loads, then a write to x0
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 1'b1, 5'(i), 32'(i * 32'h11), 1'b0, 3'b000);
         push(1'b1, 5'(i), 32'(i * 32'h11), 1'b0);
         #1 check("b2b_in_ready", 64'(in_ready), 64'd1);
         step();
      end
      drive(1'b1, 1'b1, 5'd0, 32'hAAAA_5555, 1'b0, 3'b000);
      exp_instret = exp_instret + 64'd1;
      step();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000);
      #1 check("x0_rf_we", 64'(rf_we), 64'd0);
      check("x0_instret", instret, exp_instret);
      step();

      // rdy low during WAIT with a response pulsed meanwhile
      drive(1'b1, 1'b1, 5'd11, 32'h0000_0100, 1'b1, 3'b010);
      push(1'b1, 5'd11, 32'hCAFE_F00D, 1'b0);
      step();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000);
      rdy = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         #1 check("rdy_lo_stall", 64'(stall_req), 64'd1);
         check("rdy_lo_in_ready", 64'(in_ready), 64'd0);
         step();
      end
      rdy = 1'b1; dmem_rvalid = 1'b0;
      #1 check("rdy_back_stall", 64'(stall_req), 64'd1);
      check("rdy_lo_instret", instret, exp_instret - 64'd1);
      step();
      dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      step();
      dmem_rvalid = 1'b0;
      #1 check("rdy_instret", instret, exp_instret);
      step();

      // reset during WAIT abandons the load
      drive(1'b1, 1'b1, 5'd12, 32'h0000_0100, 1'b1, 3'b010);
      step();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000);
      rst = 1'b0;
      step();
      rst = 1'b1; dmem_rvalid = 1'b1;
      #1 check("wrst_stall", 64'(stall_req), 64'd0);
      step();
      dmem_rvalid = 1'b0;
      #1 check("wrst_rf_we", 64'(rf_we), 64'd0);
      check("wrst_instret", instret, 64'd0);
      check("wrst_waddr", 64'(rf_waddr), 64'd0);
      step();
      step();

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
